// File: rtl/spart_pkg.sv
// Shared constants for the SPART bus/FIFO interface: register map and status bit positions.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam int unsigned ST_RDA      = 0;
  localparam int unsigned ST_TBR      = 1;
  localparam int unsigned ST_RX_FULL  = 2;
  localparam int unsigned ST_TX_EMPTY = 3;
  localparam int unsigned ST_OVERRUN  = 4;

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock FIFO with combinational head; a push into a full FIFO succeeds only when a pop
// happens in the same cycle, and a pop of an empty FIFO is ignored.
module spart_sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             head_c,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_pop_c;
  logic              do_push_c;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head_c    = mem[rd_ptr];
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spart_bus_fifo_if.sv
// Processor-bus front end for the SPART: RX/TX FIFOs, status, baud divisor, transmit sequencing.
// Optional interrupt output enabled by defining SPART_BUS_IRQ_EN.
module spart_bus_fifo_if
  import spart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iocs,
  input  logic              iorw,
  input  logic [1:0]        ioaddr,
  inout  wire  [DATA_W-1:0] databus,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic [DIV_W-1:0]  divisor
`ifdef SPART_BUS_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic              rd_acc_c, wr_acc_c, stat_rd_c;
  logic              rx_pop_c, tx_push_c, tx_pop_c, ovr_set_c;
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic [DATA_W-1:0] rx_head_c, tx_head_c, rd_data_c;
  logic [CW-1:0]     rx_count, tx_count;
  logic              overrun;
  logic              unused_counts;

  assign rd_acc_c  = iocs & iorw;
  assign wr_acc_c  = iocs & ~iorw;
  assign stat_rd_c = rd_acc_c & (ioaddr == ADDR_STATUS);
  assign rx_pop_c  = rd_acc_c & (ioaddr == ADDR_DATA);
  assign tx_push_c = wr_acc_c & (ioaddr == ADDR_DATA);
  assign tx_pop_c  = ~tx_empty & ~tx_busy & ~tx_start;
  assign ovr_set_c = rx_valid & rx_full & ~rx_pop_c;

  assign unused_counts = ^{rx_count, tx_count};

  spart_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop_c),
    .head_c    (rx_head_c),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  spart_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push_c),
    .push_data (databus),
    .pop       (tx_pop_c),
    .head_c    (tx_head_c),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // Read mux; empty data reads and divisor addresses return zero
  always_comb begin
    rd_data_c = '0;
    case (ioaddr)
      ADDR_DATA: begin
        if (!rx_empty) rd_data_c = rx_head_c;
      end
      ADDR_STATUS: begin
        rd_data_c[ST_RDA]      = ~rx_empty;
        rd_data_c[ST_TBR]      = ~tx_full;
        rd_data_c[ST_RX_FULL]  = rx_full;
        rd_data_c[ST_TX_EMPTY] = tx_empty;
        rd_data_c[ST_OVERRUN]  = overrun;
      end
      default: ;
    endcase
  end

  assign databus = rd_acc_c ? rd_data_c : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      divisor  <= '0;
    end else begin
      if (ovr_set_c)      overrun <= 1'b1;
      else if (stat_rd_c) overrun <= 1'b0;
      tx_start <= tx_pop_c;
      if (tx_pop_c) tx_data <= tx_head_c;
      if (wr_acc_c && (ioaddr == ADDR_DIV_LO)) divisor[DATA_W-1:0] <= databus;
      if (wr_acc_c && (ioaddr == ADDR_DIV_HI)) divisor[DIV_W-1:DATA_W] <= (DIV_W-DATA_W)'(databus);
    end
  end

`ifdef SPART_BUS_IRQ_EN
  logic tx_was_busy;
  logic tx_done_lat;

  // Transmit-complete event holds until software reads status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_was_busy <= 1'b0;
      tx_done_lat <= 1'b0;
      irq         <= 1'b0;
    end else begin
      tx_was_busy <= ~tx_empty;
      if (tx_empty && tx_was_busy) tx_done_lat <= 1'b1;
      else if (stat_rd_c)          tx_done_lat <= 1'b0;
      irq <= ~rx_empty | overrun | tx_done_lat;
    end
  end
`endif

endmodule

// File: tb/tb_spart_bus_fifo_if.sv
// Scoreboard bench for spart_bus_fifo_if: queue-based reference model, decoupled monitor.
module tb_spart_bus_fifo_if;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iocs, iorw;
  logic [1:0]  ioaddr;
  wire  [7:0]  databus;
  logic        drv_en;
  logic [7:0]  drv_val;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] divisor;

  assign databus = drv_en ? drv_val : 8'hzz;

  always #5 clk = ~clk;

  spart_bus_fifo_if dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .divisor  (divisor)
  );

  typedef struct {
    logic        rd;
    logic [7:0]  rval;
    logic [7:0]  busval;
    logic        start;
    logic [15:0] div;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] txexp[$];

  // Reference model state: plain queues and flags
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic        m_ovr;
  logic        m_start;
  logic [15:0] m_div;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    rxq.delete();
    txq.delete();
    txexp.delete();
    m_ovr   = 1'b0;
    m_start = 1'b0;
    m_div   = 16'h0;
  endfunction

  // One bus cycle: drive at negedge, record expectation, advance the model across the next edge
  task automatic step(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] w,
                      input logic rv, input logic [7:0] rin, input logic busy);
    exp_t e;
    logic pop_rx, drain, ovr_set;
    @(negedge clk);
    iocs = cs; iorw = rw; ioaddr = a;
    drv_en = !(cs && rw); drv_val = w;
    rx_valid = rv; rx_data = rin; tx_busy = busy;

    e.rd = cs && rw;
    e.busval = w;
    e.start = m_start;
    e.div = m_div;
    e.rval = 8'h00;
    if (a == 2'b00 && rxq.size() > 0) e.rval = rxq[0];
    if (a == 2'b01) e.rval = {3'b000, m_ovr, txq.size() == 0, rxq.size() == D,
                              txq.size() < D, rxq.size() != 0};
    expq.push_back(e);

    pop_rx  = e.rd && a == 2'b00 && rxq.size() > 0;
    drain   = txq.size() > 0 && !busy && !m_start;
    ovr_set = 1'b0;
    if (pop_rx) void'(rxq.pop_front());
    if (rv) begin
      if (rxq.size() < D) rxq.push_back(rin);
      else ovr_set = 1'b1;
    end
    if (ovr_set) m_ovr = 1'b1;
    else if (e.rd && a == 2'b01) m_ovr = 1'b0;
    if (drain) txexp.push_back(txq.pop_front());
    if (cs && !rw && a == 2'b00 && txq.size() < D) txq.push_back(w);
    if (cs && !rw && a == 2'b10) m_div[7:0] = w;
    if (cs && !rw && a == 2'b11) m_div[15:8] = w;
    m_start = drain;
  endtask

  task automatic idle(input logic busy);
    step(1'b0, 1'b0, 2'(($urandom)), 8'($urandom), 1'b0, 8'h00, busy);
  endtask
  task automatic rd(input logic [1:0] a, input logic busy);
    step(1'b1, 1'b1, a, 8'h00, 1'b0, 8'h00, busy);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] v, input logic busy);
    step(1'b1, 1'b0, a, v, 1'b0, 8'h00, busy);
  endtask
  task automatic rxin(input logic [7:0] v, input logic busy);
    step(1'b0, 1'b1, 2'b00, 8'($urandom), 1'b1, v, busy);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    iocs = 1'b0; rx_valid = 1'b0; drv_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_divisor", 32'(divisor), 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: samples well clear of the rising edge and pops one expectation per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && expq.size() > 0) begin
        e = expq.pop_front();
        if (e.rd) check("rdata", 32'(databus), 32'(e.rval));
        else      check("bus_not_driven", 32'(databus), 32'(e.busval));
        check("tx_start", 32'(tx_start), 32'(e.start));
        check("divisor", 32'(divisor), 32'(e.div));
        if (tx_start) begin
          if (txexp.size() > 0) check("tx_data", 32'(tx_data), 32'(txexp.pop_front()));
          else check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    drv_en = 1'b1; drv_val = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    model_reset();
    #1;
    check("reset_tx_start", 32'(tx_start), 32'h0);
    check("reset_tx_data", 32'(tx_data), 32'h0);
    check("reset_divisor", 32'(divisor), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single received byte, status and data reads
    rxin(8'hA5, 1'b0);
    rd(2'b01, 1'b0);
    rd(2'b00, 1'b0);
    rd(2'b01, 1'b0);
    rd(2'b00, 1'b0);

    // Overrun on fifth byte, sticky until status read
    for (int i = 1; i <= 5; i++) rxin(8'(i), 1'b0);
    rd(2'b01, 1'b0);
    for (int i = 0; i < 4; i++) rd(2'b00, 1'b0);
    rd(2'b01, 1'b0);
    rd(2'b01, 1'b0);

    // Single transmit with idle transmitter
    wr(2'b00, 8'h3C, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Transmitter busy: fill TX, fifth write dropped, then drain in order
    for (int i = 0; i < 5; i++) wr(2'b00, 8'h40 + 8'(i), 1'b1);
    rd(2'b01, 1'b1);
    for (int i = 0; i < 10; i++) idle(1'b0);

    // Divisor bytes, divisor-address reads, then reset mid-stream
    wr(2'b10, 8'h34, 1'b0);
    wr(2'b11, 8'h12, 1'b0);
    rd(2'b10, 1'b0);
    rd(2'b11, 1'b0);
    rxin(8'h77, 1'b1);
    wr(2'b00, 8'h99, 1'b1);
    wr(2'b00, 8'h9A, 1'b1);
    reset_mid();
    idle(1'b0);
    rd(2'b01, 1'b0);
    rd(2'b00, 1'b0);

    // RX full with simultaneous pop and receive: no overrun
    for (int i = 0; i < 4; i++) rxin(8'hB0 + 8'(i), 1'b0);
    step(1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 8'hC4, 1'b0);
    rd(2'b01, 1'b0);
    for (int i = 0; i < 5; i++) rd(2'b00, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic cs, rw, rv, busy;
      cs   = ($urandom_range(0, 99) < 60);
      rw   = ($urandom_range(0, 1) == 1);
      rv   = ($urandom_range(0, 99) < 35);
      busy = ($urandom_range(0, 99) < 40);
      step(cs, rw, 2'($urandom), 8'($urandom), rv, 8'($urandom), busy);
      if (i == 300) reset_mid();
    end

    for (int i = 0; i < 14; i++) idle(1'b0);
    @(negedge clk);
    #4;
    check("tx_all_sent", 32'(txexp.size()), 32'h0);
    check("exp_queue_drained", 32'(expq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
